// File: rtl/lsu_axi_master_if.sv
// AXI-lite channel bundle between the load/store unit (master) and memory (slave).
interface lsu_axi_master_if;
  logic        awvalid, awready;
  logic [31:0] awaddr;
  logic        wvalid, wready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        bvalid, bready;
  logic [1:0]  bresp;
  logic        arvalid, arready;
  logic [31:0] araddr;
  logic        rvalid, rready;
  logic [31:0] rdata;
  logic [1:0]  rresp;

  modport master (
    output awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
    input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );
  modport slave (
    input  awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
    output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );
endinterface

// File: rtl/lsu_axi_master.sv
// Single-outstanding LSU bus master: one request -> one AXI-lite read or write.
// Optional per-phase watchdog enabled with `define LSU_TIMEOUT_EN.
module lsu_axi_master #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic        i_req_wen,
  input  logic [31:0] i_req_addr,
  input  logic [31:0] i_req_wdata,
  input  logic [1:0]  i_req_size,
  input  logic        i_req_unsigned,
  output logic        o_resp_valid,
  input  logic        i_resp_ready,
  output logic [31:0] o_resp_rdata,
  output logic [1:0]  o_resp_err,
  lsu_axi_master_if.master mem
);

  typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, RESP} state_t;

  state_t      r_state, w_next;
  logic [31:0] r_addr, r_wdata, r_rdata;
  logic [3:0]  r_wstrb;
  logic [1:0]  r_size, r_err;
  logic        r_unsigned, r_aw_done, r_w_done;

  logic        w_misalign, w_accept;
  logic        w_ar_hs, w_r_hs, w_aw_hs, w_w_hs, w_b_hs, w_wr_both;
  logic        w_wait_st, w_wait_hs, w_expire, w_timeout;
  logic [31:0] w_shift, w_load, w_st_data;
  logic [3:0]  w_st_strb;

  assign w_misalign = (i_req_size == 2'd3) ||
                      (i_req_size == 2'd1 && i_req_addr[0]) ||
                      (i_req_size == 2'd2 && i_req_addr[1:0] != 2'b00);
  assign w_accept   = (r_state == IDLE) && i_req_valid;

  assign w_ar_hs   = mem.arvalid && mem.arready;
  assign w_r_hs    = mem.rvalid  && mem.rready;
  assign w_aw_hs   = mem.awvalid && mem.awready;
  assign w_w_hs    = mem.wvalid  && mem.wready;
  assign w_b_hs    = mem.bvalid  && mem.bready;
  assign w_wr_both = (r_aw_done || w_aw_hs) && (r_w_done || w_w_hs);

  always_comb begin
    w_wait_st = 1'b1;
    w_wait_hs = 1'b0;
    case (r_state)
      RD_ADDR: w_wait_hs = w_ar_hs;
      RD_DATA: w_wait_hs = w_r_hs;
      WR_REQ:  w_wait_hs = w_wr_both;
      WR_RESP: w_wait_hs = w_b_hs;
      default: w_wait_st = 1'b0;
    endcase
  end

`ifdef LSU_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [CNT_W-1:0] r_cnt;

  // Restarts on every state change so each bus phase gets its own budget.
  always_ff @(posedge i_clock) begin
    if (i_reset || w_next != r_state) r_cnt <= '0;
    else if (w_wait_st)               r_cnt <= r_cnt + 1'b1;
  end
  assign w_expire = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign w_expire = 1'b0;
`endif

  // A handshake landing on the expiry cycle takes priority over the timeout.
  assign w_timeout = w_wait_st && !w_wait_hs && w_expire;

  // Load lane extraction from the returning read beat
  assign w_shift = mem.rdata >> {r_addr[1:0], 3'b000};
  always_comb begin
    case (r_size)
      2'd0:    w_load = r_unsigned ? {24'h0, w_shift[7:0]} : {{24{w_shift[7]}}, w_shift[7:0]};
      2'd1:    w_load = r_unsigned ? {16'h0, w_shift[15:0]} : {{16{w_shift[15]}}, w_shift[15:0]};
      default: w_load = mem.rdata;
    endcase
  end

  always_comb begin
    case (i_req_size)
      2'd0: begin
        w_st_data = {4{i_req_wdata[7:0]}};
        w_st_strb = 4'b0001 << i_req_addr[1:0];
      end
      2'd1: begin
        w_st_data = {2{i_req_wdata[15:0]}};
        w_st_strb = 4'b0011 << i_req_addr[1:0];
      end
      default: begin
        w_st_data = i_req_wdata;
        w_st_strb = 4'b1111;
      end
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) r_state <= IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (i_req_valid) w_next = w_misalign ? RESP : (i_req_wen ? WR_REQ : RD_ADDR);
      RD_ADDR: if (w_ar_hs) w_next = RD_DATA; else if (w_timeout) w_next = RESP;
      RD_DATA: if (w_r_hs || w_timeout) w_next = RESP;
      WR_REQ:  if (w_wr_both) w_next = WR_RESP; else if (w_timeout) w_next = RESP;
      WR_RESP: if (w_b_hs || w_timeout) w_next = RESP;
      RESP:    if (i_resp_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    o_req_ready  = 1'b0;
    o_resp_valid = 1'b0;
    mem.arvalid  = 1'b0;
    mem.rready   = 1'b0;
    mem.awvalid  = 1'b0;
    mem.wvalid   = 1'b0;
    mem.bready   = 1'b0;
    case (r_state)
      IDLE:    o_req_ready = 1'b1;
      RD_ADDR: mem.arvalid = 1'b1;
      RD_DATA: mem.rready  = 1'b1;
      WR_REQ: begin
        mem.awvalid = !r_aw_done;
        mem.wvalid  = !r_w_done;
      end
      WR_RESP: mem.bready   = 1'b1;
      RESP:    o_resp_valid = 1'b1;
      default: ;
    endcase
  end

  assign mem.araddr   = {r_addr[31:2], 2'b00};
  assign mem.awaddr   = {r_addr[31:2], 2'b00};
  assign mem.wdata    = r_wdata;
  assign mem.wstrb    = r_wstrb;
  assign o_resp_rdata = r_rdata;
  assign o_resp_err   = r_err;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_addr     <= '0;
      r_wdata    <= '0;
      r_wstrb    <= '0;
      r_size     <= '0;
      r_unsigned <= 1'b0;
      r_aw_done  <= 1'b0;
      r_w_done   <= 1'b0;
      r_rdata    <= '0;
      r_err      <= '0;
    end else begin
      if (w_accept) begin
        r_addr     <= i_req_addr;
        r_wdata    <= w_st_data;
        r_wstrb    <= w_st_strb;
        r_size     <= i_req_size;
        r_unsigned <= i_req_unsigned;
        r_aw_done  <= 1'b0;
        r_w_done   <= 1'b0;
        if (w_misalign) begin
          r_rdata <= '0;
          r_err   <= 2'b11;
        end
      end
      if (r_state == WR_REQ && w_aw_hs) r_aw_done <= 1'b1;
      if (r_state == WR_REQ && w_w_hs)  r_w_done  <= 1'b1;
      if (r_state == RD_DATA && w_r_hs) begin
        r_rdata <= (mem.rresp != 2'b00) ? 32'h0 : w_load;
        r_err   <= mem.rresp;
      end
      if (r_state == WR_RESP && w_b_hs) begin
        r_rdata <= '0;
        r_err   <= mem.bresp;
      end
      if (w_timeout) begin
        r_rdata <= '0;
        r_err   <= 2'b11;
      end
    end
  end

endmodule

// File: tb/tb_lsu_axi_master.sv
// Scoreboard bench for lsu_axi_master: directed requests, AXI-lite slave model, negedge monitor.
module tb_lsu_axi_master;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic        req_valid = 1'b0, req_wen = 1'b0, req_unsigned = 1'b0, resp_ready = 1'b1;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic [1:0]  req_size = '0;
  logic        req_ready, resp_valid;
  logic [31:0] resp_rdata;
  logic [1:0]  resp_err;

  lsu_axi_master_if mem_if();

  lsu_axi_master #(.TIMEOUT_CYCLES(16)) dut (
    .i_clock(clock), .i_reset(reset),
    .i_req_valid(req_valid), .o_req_ready(req_ready), .i_req_wen(req_wen),
    .i_req_addr(req_addr), .i_req_wdata(req_wdata), .i_req_size(req_size),
    .i_req_unsigned(req_unsigned),
    .o_resp_valid(resp_valid), .i_resp_ready(resp_ready),
    .o_resp_rdata(resp_rdata), .o_resp_err(resp_err),
    .mem(mem_if)
  );

  int checks = 0, errors = 0;
  logic [33:0] exp_resp[$];
  logic [31:0] exp_ar[$], exp_aw[$];
  logic [35:0] exp_w[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name);
    checks++;
    errors++;
    $display("FAIL %s: DUT output with no expected entry queued", name);
  endtask

  // Slave model: hands-shake decisions sampled at negedge, outputs updated after posedge
  bit          ar_block = 0, r_hold = 0;
  int          wmode = 0;
  logic [31:0] slv_rdata = '0;
  logic [1:0]  slv_rresp = '0, slv_bresp = '0;
  int          ar_cycles = 0;

  initial begin
    bit ar_hs, r_hs, aw_hs, w_hs, b_hs, aw_got, w_got;
    aw_got = 0; w_got = 0;
    mem_if.arready = 0; mem_if.rvalid = 0; mem_if.rdata = '0; mem_if.rresp = '0;
    mem_if.awready = 0; mem_if.wready = 0; mem_if.bvalid = 0; mem_if.bresp = '0;
    forever begin
      @(negedge clock);
      ar_hs = mem_if.arvalid && mem_if.arready;
      r_hs  = mem_if.rvalid  && mem_if.rready;
      aw_hs = mem_if.awvalid && mem_if.awready;
      w_hs  = mem_if.wvalid  && mem_if.wready;
      b_hs  = mem_if.bvalid  && mem_if.bready;
      @(posedge clock); #1;
      mem_if.arready = !ar_block;
      if (ar_hs && !r_hold) begin
        mem_if.rvalid = 1; mem_if.rdata = slv_rdata; mem_if.rresp = slv_rresp;
      end else if (r_hs) mem_if.rvalid = 0;
      if (aw_hs) aw_got = 1;
      if (w_hs)  w_got  = 1;
      if (b_hs)  mem_if.bvalid = 0;
      if (aw_got && w_got) begin
        mem_if.bvalid = 1; mem_if.bresp = slv_bresp; aw_got = 0; w_got = 0;
      end
      case (wmode)
        1:       begin mem_if.awready = 1; mem_if.wready = aw_got; end
        2:       begin mem_if.wready = 1; mem_if.awready = w_got; end
        default: begin mem_if.awready = 1; mem_if.wready = 1; end
      endcase
    end
  end

  // Monitor: pops expectations whenever the DUT completes a handshake
  always @(negedge clock) begin
    if (!reset) begin
      if (mem_if.arvalid) ar_cycles++;
      if (mem_if.arvalid && mem_if.arready) begin
        if (exp_ar.size() == 0) unexpected("araddr");
        else chk("araddr", mem_if.araddr, exp_ar.pop_front());
      end
      if (mem_if.awvalid && mem_if.awready) begin
        if (exp_aw.size() == 0) unexpected("awaddr");
        else chk("awaddr", mem_if.awaddr, exp_aw.pop_front());
      end
      if (mem_if.wvalid && mem_if.wready) begin
        if (exp_w.size() == 0) unexpected("wdata");
        else begin
          logic [35:0] e;
          e = exp_w.pop_front();
          chk("wdata", mem_if.wdata, e[35:4]);
          chk("wstrb", {28'h0, mem_if.wstrb}, {28'h0, e[3:0]});
        end
      end
      if (resp_valid && resp_ready) begin
        if (exp_resp.size() == 0) unexpected("resp");
        else begin
          logic [33:0] e;
          e = exp_resp.pop_front();
          chk("resp_rdata", resp_rdata, e[33:2]);
          chk("resp_err", {30'h0, resp_err}, {30'h0, e[1:0]});
        end
      end
    end
  end

  task automatic issue(input logic wen, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [1:0] sz, input logic uns);
    int n;
    n = 0;
    req_valid = 1; req_wen = wen; req_addr = addr; req_wdata = wd;
    req_size = sz; req_unsigned = uns;
    do begin @(negedge clock); n++; end while (!req_ready && n < 50);
    if (!req_ready) begin
      checks++; errors++;
      $display("FAIL req_accept: req_ready stayed %b, required 1", req_ready);
    end
    @(posedge clock); #1;
    req_valid = 0;
  endtask

  task automatic wait_resp(output int lat, output logic arv);
    lat = 0;
    do begin @(negedge clock); lat++; end while (!resp_valid && lat < 200);
    arv = mem_if.arvalid;
    if (!resp_valid) begin
      checks++; errors++;
      $display("FAIL resp_wait: resp_valid=%b after %0d cycles, required 1", resp_valid, lat);
    end
    @(posedge clock); #1;
  endtask

  task automatic cfg_cycle();
    @(posedge clock); #1;
  endtask

  initial begin
    int   lat, ar0;
    logic arv;

    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_resp_valid", {31'h0, resp_valid}, 0);
    chk("rst_arvalid", {31'h0, mem_if.arvalid}, 0);
    chk("rst_awvalid", {31'h0, mem_if.awvalid}, 0);
    chk("rst_wvalid", {31'h0, mem_if.wvalid}, 0);
    chk("rst_rready", {31'h0, mem_if.rready}, 0);
    chk("rst_bready", {31'h0, mem_if.bready}, 0);
    chk("rst_rdata", resp_rdata, 0);
    chk("rst_err", {30'h0, resp_err}, 0);
    @(posedge clock); #1;
    reset = 0;
    @(posedge clock);
    @(negedge clock);
    chk("rst_req_ready", {31'h0, req_ready}, 1);
    @(posedge clock); #1;

    // Word load, zero-wait slave
    slv_rdata = 32'hDEADBEEF; slv_rresp = 2'b00; cfg_cycle();
    exp_ar.push_back(32'h80000004); exp_resp.push_back({32'hDEADBEEF, 2'b00});
    issue(0, 32'h80000004, 0, 2'd2, 0);
    wait_resp(lat, arv);
    chk("ld_word_latency", lat, 3);

    // Byte loads, lane 3, signed then unsigned
    slv_rdata = 32'h80112233; cfg_cycle();
    exp_ar.push_back(32'h80000000); exp_resp.push_back({32'hFFFFFF80, 2'b00});
    issue(0, 32'h80000003, 0, 2'd0, 0);
    wait_resp(lat, arv);
    exp_ar.push_back(32'h80000000); exp_resp.push_back({32'h00000080, 2'b00});
    issue(0, 32'h80000003, 0, 2'd0, 1);
    wait_resp(lat, arv);

    // Signed half load from the upper lane
    slv_rdata = 32'hA5A51234; cfg_cycle();
    exp_ar.push_back(32'h80000004); exp_resp.push_back({32'hFFFFA5A5, 2'b00});
    issue(0, 32'h80000006, 0, 2'd1, 0);
    wait_resp(lat, arv);

    // Read error: data forced to zero, rresp forwarded
    slv_rdata = 32'h12345678; slv_rresp = 2'b10; cfg_cycle();
    exp_ar.push_back(32'h80000008); exp_resp.push_back({32'h0, 2'b10});
    issue(0, 32'h80000008, 0, 2'd2, 0);
    wait_resp(lat, arv);
    slv_rresp = 2'b00;

    // Half store, wready only after aw handshake, then wready first
    wmode = 1; slv_bresp = 2'b00; cfg_cycle();
    exp_aw.push_back(32'h80000000); exp_w.push_back({32'hABCDABCD, 4'b1100});
    exp_resp.push_back({32'h0, 2'b00});
    issue(1, 32'h80000002, 32'h0000ABCD, 2'd1, 0);
    wait_resp(lat, arv);
    wmode = 2; cfg_cycle();
    exp_aw.push_back(32'h80000000); exp_w.push_back({32'hABCDABCD, 4'b1100});
    exp_resp.push_back({32'h0, 2'b00});
    issue(1, 32'h80000002, 32'h0000ABCD, 2'd1, 0);
    wait_resp(lat, arv);

    // Byte store with slave error, then word store
    wmode = 0; slv_bresp = 2'b10; cfg_cycle();
    exp_aw.push_back(32'h80000000); exp_w.push_back({32'hEFEFEFEF, 4'b0010});
    exp_resp.push_back({32'h0, 2'b10});
    issue(1, 32'h80000001, 32'h123456EF, 2'd0, 0);
    wait_resp(lat, arv);
    slv_bresp = 2'b00; cfg_cycle();
    exp_aw.push_back(32'h8000000C); exp_w.push_back({32'h11223344, 4'b1111});
    exp_resp.push_back({32'h0, 2'b00});
    issue(1, 32'h8000000C, 32'h11223344, 2'd2, 0);
    wait_resp(lat, arv);

    // Misaligned word load with back-pressure on the response
    resp_ready = 0; ar0 = ar_cycles;
    exp_resp.push_back({32'h0, 2'b11});
    issue(0, 32'h80000001, 0, 2'd2, 0);
    @(negedge clock);
    chk("mis_resp_valid", {31'h0, resp_valid}, 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      chk("mis_hold_valid", {31'h0, resp_valid}, 1);
      chk("mis_hold_err", {30'h0, resp_err}, 32'h3);
      chk("mis_hold_rdata", resp_rdata, 0);
    end
    @(posedge clock); #1;
    resp_ready = 1;
    @(posedge clock); #1;
    chk("mis_no_arvalid", ar_cycles - ar0, 0);

    // Reserved size is always misaligned
    exp_resp.push_back({32'h0, 2'b11});
    issue(0, 32'h80000000, 0, 2'd3, 0);
    wait_resp(lat, arv);
    chk("size3_latency", lat, 1);

    // Reset while waiting in RD_DATA, then a clean load
    r_hold = 1; cfg_cycle();
    exp_ar.push_back(32'h80000010);
    issue(0, 32'h80000010, 0, 2'd2, 0);
    @(negedge clock);
    @(negedge clock);
    chk("rd_data_rready", {31'h0, mem_if.rready}, 1);
    @(posedge clock); #1;
    reset = 1;
    @(posedge clock);
    @(negedge clock);
    chk("rst_mid_arvalid", {31'h0, mem_if.arvalid}, 0);
    chk("rst_mid_rready", {31'h0, mem_if.rready}, 0);
    chk("rst_mid_resp_valid", {31'h0, resp_valid}, 0);
    @(posedge clock); #1;
    reset = 0; r_hold = 0;
    @(posedge clock);
    @(negedge clock);
    chk("rst_mid_req_ready", {31'h0, req_ready}, 1);
    @(posedge clock); #1;
    slv_rdata = 32'hCAFEF00D; cfg_cycle();
    exp_ar.push_back(32'h80000014); exp_resp.push_back({32'hCAFEF00D, 2'b00});
    issue(0, 32'h80000014, 0, 2'd2, 0);
    wait_resp(lat, arv);
    chk("post_rst_latency", lat, 3);

`ifdef LSU_TIMEOUT_EN
    // Slave never grants arready: watchdog ends the read phase
    ar_block = 1; cfg_cycle();
    exp_resp.push_back({32'h0, 2'b11});
    issue(0, 32'h80000020, 0, 2'd2, 0);
    wait_resp(lat, arv);
    chk("timeout_cycles_from_entry", lat - 1, 16);
    chk("timeout_arvalid_dropped", {31'h0, arv}, 0);
    ar_block = 0; cfg_cycle();
`endif

    repeat (5) @(posedge clock);
    chk("scoreboard_empty", exp_resp.size() + exp_ar.size() + exp_aw.size() + exp_w.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
